// File: rtl/mtr_drv_pkg.sv
// Shared constants, duty typedef and the saturate-and-offset helper
// for the multi-channel ramped motor driver.
package mtr_drv_pkg;

    localparam logic signed [12:0] UNITY_SCALE = 13'sh800;
    localparam int                 DIV_SHIFT   = 11;
    localparam int                 DUTY_W      = 12;

    typedef logic [DUTY_W-1:0] duty_t;

    // Clamp q to +/-(mid-1) and place it around mid-scale; inv reverses direction.
    function automatic logic [31:0] sat_duty(
        input logic signed [47:0] q,
        input int                 pwm_w,
        input logic               inv
    );
        logic signed [47:0] mid;
        logic signed [47:0] lim;
        logic signed [47:0] qs;
        logic signed [47:0] d;
        mid = 48'sd1 <<< (pwm_w - 1);
        lim = mid - 48'sd1;
        if (q > lim) begin
            qs = lim;
        end else if (q < -lim) begin
            qs = -lim;
        end else begin
            qs = q;
        end
        if (inv) begin
            d = mid - qs;
        end else begin
            d = mid + qs;
        end
        return 32'(d);
    endfunction

endpackage

// File: rtl/mtr_drv_ramp_ch.sv
// One motor channel: slew-limited duty register, brake override,
// dead-time PWM pair comparators and the at-target flag.
module mtr_ch_ramp
    import mtr_drv_pkg::*;
#(
    parameter int PWM_W     = 12,
    parameter int DEAD      = 16,
    parameter int RAMP_STEP = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt_nxt,
    input  logic             prd_end,
    input  logic             brake,
    input  logic [PWM_W-1:0] duty_tgt,
    output logic             pwm1,
    output logic             pwm2,
    output logic             at_tgt
);

    localparam logic [PWM_W-1:0] MID    = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W:0]   DEAD_X = (PWM_W+1)'(DEAD);
    localparam logic [PWM_W:0]   STEP_X = (PWM_W+1)'(RAMP_STEP);

    logic [PWM_W-1:0] duty_act_r;
    logic [PWM_W-1:0] duty_nxt_s;
    logic [PWM_W:0]   act_x_s;
    logic [PWM_W:0]   tgt_x_s;
    logic [PWM_W:0]   cnt_x_s;
    logic [PWM_W:0]   edge2_s;
    logic             pwm1_s;
    logic             pwm2_s;
    logic             pwm1_r;
    logic             pwm2_r;

    // Next duty: brake re-centres, otherwise one bounded step toward target per period.
    always_comb begin
        act_x_s    = {1'b0, duty_act_r};
        tgt_x_s    = {1'b0, duty_tgt};
        duty_nxt_s = duty_act_r;
        if (brake) begin
            duty_nxt_s = MID;
        end else if (!prd_end) begin
            duty_nxt_s = duty_act_r;
        end else if (RAMP_STEP == 0) begin
            duty_nxt_s = duty_tgt;
        end else if (tgt_x_s > act_x_s + STEP_X) begin
            duty_nxt_s = PWM_W'(act_x_s + STEP_X);
        end else if (act_x_s > tgt_x_s + STEP_X) begin
            duty_nxt_s = PWM_W'(act_x_s - STEP_X);
        end else begin
            duty_nxt_s = duty_tgt;
        end
    end

    // Compare against the upcoming count and duty so registered pwm lines align with cnt.
    always_comb begin
        cnt_x_s = {1'b0, cnt_nxt};
        edge2_s = {1'b0, duty_nxt_s} + DEAD_X;
        pwm1_s  = (cnt_x_s >= DEAD_X) && (cnt_x_s < {1'b0, duty_nxt_s});
        pwm2_s  = (cnt_x_s >= edge2_s);
    end

    // Duty register and registered PWM pair; brake drops both legs on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act_r <= MID;
            pwm1_r     <= 1'b0;
            pwm2_r     <= 1'b0;
        end else begin
            duty_act_r <= duty_nxt_s;
            if (brake) begin
                pwm1_r <= 1'b0;
                pwm2_r <= 1'b0;
            end else begin
                pwm1_r <= pwm1_s;
                pwm2_r <= pwm2_s;
            end
        end
    end

    assign pwm1   = pwm1_r;
    assign pwm2   = pwm2_r;
    assign at_tgt = (duty_act_r == duty_tgt);

endmodule

// File: rtl/mtr_drv_ramp.sv
// Multi-channel motor driver: captures and scales signed speed commands,
// saturates them to duty targets and drives ramped dead-time PWM pairs.
module mtr_drv_ramp
    import mtr_drv_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                SPD_W     = 12,
    parameter int                PWM_W     = 12,
    parameter int                DEAD      = 16,
    parameter int                RAMP_STEP = 64,
    parameter logic [NUM_CH-1:0] INV_MASK  = 2'b10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*SPD_W-1:0] spd,
    input  logic signed [12:0]      scale,
    input  logic                    brake,
    output logic [NUM_CH-1:0]       pwm1,
    output logic [NUM_CH-1:0]       pwm2,
    output logic [NUM_CH-1:0]       at_tgt,
    output logic                    prd_end
);

    localparam int                       PROD_W  = SPD_W + 13;
    localparam logic [PWM_W-1:0]         MID     = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0]         CNT_MAX = {PWM_W{1'b1}};
    localparam logic signed [PROD_W-1:0] RND     = PROD_W'((32'd1 << DIV_SHIFT) - 32'd1);

    logic [NUM_CH*SPD_W-1:0]      spd_r;
    logic signed [12:0]           scale_r;
    logic [NUM_CH-1:0][PWM_W-1:0] duty_tgt_r;
    logic [NUM_CH-1:0][PWM_W-1:0] tgt_nxt_s;
    logic [PWM_W-1:0]             cnt_r;
    logic [PWM_W-1:0]             cnt_nxt_s;
    logic                         prd_end_r;

    // Scale, divide toward zero (bias negatives before the shift) and saturate per channel.
    always_comb begin : tgt_calc
        logic signed [PROD_W-1:0] a_v;
        logic signed [PROD_W-1:0] b_v;
        logic signed [PROD_W-1:0] prod_v;
        logic signed [PROD_W-1:0] q_v;
        a_v       = '0;
        b_v       = '0;
        prod_v    = '0;
        q_v       = '0;
        tgt_nxt_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            a_v    = PROD_W'($signed(spd_r[i*SPD_W +: SPD_W]));
            b_v    = PROD_W'(scale_r);
            prod_v = a_v * b_v;
            if (prod_v[PROD_W-1]) begin
                q_v = (prod_v + RND) >>> DIV_SHIFT;
            end else begin
                q_v = prod_v >>> DIV_SHIFT;
            end
            tgt_nxt_s[i] = PWM_W'(sat_duty(48'(q_v), PWM_W, INV_MASK[i]));
        end
    end

    assign cnt_nxt_s = cnt_r + {{(PWM_W-1){1'b0}}, 1'b1};

    // Input capture, target pipeline, shared period counter and end-of-period pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_r      <= '0;
            scale_r    <= '0;
            duty_tgt_r <= {NUM_CH{MID}};
            cnt_r      <= '0;
            prd_end_r  <= 1'b0;
        end else begin
            spd_r      <= spd;
            scale_r    <= scale;
            duty_tgt_r <= tgt_nxt_s;
            cnt_r      <= cnt_nxt_s;
            prd_end_r  <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign prd_end = prd_end_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mtr_ch_ramp #(
            .PWM_W     (PWM_W),
            .DEAD      (DEAD),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt_nxt  (cnt_nxt_s),
            .prd_end  (prd_end_r),
            .brake    (brake),
            .duty_tgt (duty_tgt_r[g]),
            .pwm1     (pwm1[g]),
            .pwm2     (pwm2[g]),
            .at_tgt   (at_tgt[g])
        );
    end

endmodule

// File: tb/tb_mtr_drv_ramp.sv
// Randomised bench for mtr_drv_ramp: two instances (slew-limited and unlimited)
// checked every cycle against a period-level arithmetic model.
module tb_mtr_drv_ramp;
    import mtr_drv_pkg::*;

    localparam int         NUM_CH = 2;
    localparam int         SPD_W  = 12;
    localparam int         DEAD   = 16;
    localparam int         MID    = 2048;
    localparam int         CMAX   = 4095;
    localparam logic [1:0] INV    = 2'b10;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    brake = 1'b0;
    logic [NUM_CH*SPD_W-1:0] spd   = '0;
    logic signed [12:0]      scale = '0;
    logic [NUM_CH-1:0]       pwm1_a, pwm2_a, at_a;
    logic [NUM_CH-1:0]       pwm1_b, pwm2_b, at_b;
    logic                    prd_a, prd_b;

    int n_vec = 0;
    int n_err = 0;

    // model state: [0] = ramp-limited instance, [1] = unlimited instance
    int m_cnt;
    int m_p_spd [NUM_CH];
    int m_p_scale;
    int m_tgt   [NUM_CH];
    int m_act   [2][NUM_CH];
    bit m_brk;
    int brk_left;

    always #5 clk = ~clk;

    mtr_drv_ramp #(.NUM_CH(2), .SPD_W(12), .PWM_W(12), .DEAD(16), .RAMP_STEP(64), .INV_MASK(2'b10)) u_ramp (
        .clk(clk), .rst_n(rst_n), .spd(spd), .scale(scale), .brake(brake),
        .pwm1(pwm1_a), .pwm2(pwm2_a), .at_tgt(at_a), .prd_end(prd_a));

    mtr_drv_ramp #(.NUM_CH(2), .SPD_W(12), .PWM_W(12), .DEAD(16), .RAMP_STEP(0), .INV_MASK(2'b10)) u_step (
        .clk(clk), .rst_n(rst_n), .spd(spd), .scale(scale), .brake(brake),
        .pwm1(pwm1_b), .pwm2(pwm2_b), .at_tgt(at_b), .prd_end(prd_b));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t (cnt %0d)", tag, obs, exp, $time, m_cnt);
        end
    endtask

    function automatic int ramp_lim(input int k);
        return (k == 0) ? 64 : 0;
    endfunction

    // Duty target straight from the arithmetic rules: SV int division truncates toward zero.
    function automatic int tgt_of(input int s, input int sc, input bit inv);
        int q;
        q = (s * sc) / 2048;
        if (q > MID - 1) q = MID - 1;
        else if (q < -(MID - 1)) q = -(MID - 1);
        return inv ? MID - q : MID + q;
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_p_scale = 0;
        m_brk     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_p_spd[i]  = 0;
            m_tgt[i]    = MID;
            m_act[0][i] = MID;
            m_act[1][i] = MID;
        end
    endtask

    task automatic model_edge();
        bit prd;
        int d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        prd = (m_cnt == CMAX);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d = m_tgt[i] - m_act[k][i];
                if (brake) m_act[k][i] = MID;
                else if (prd) begin
                    if (ramp_lim(k) == 0 || (d <= ramp_lim(k) && d >= -ramp_lim(k))) m_act[k][i] = m_tgt[i];
                    else if (d > 0) m_act[k][i] = m_act[k][i] + ramp_lim(k);
                    else m_act[k][i] = m_act[k][i] - ramp_lim(k);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            m_tgt[i]   = tgt_of(m_p_spd[i], m_p_scale, INV[i]);
            m_p_spd[i] = int'($signed(spd[i*SPD_W +: SPD_W]));
        end
        m_p_scale = int'(scale);
        m_cnt     = (m_cnt + 1) % 4096;
        m_brk     = brake;
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e1 [2];
        logic [NUM_CH-1:0] e2 [2];
        logic [NUM_CH-1:0] ea [2];
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                e1[k][i] = !m_brk && (m_cnt >= DEAD) && (m_cnt < m_act[k][i]);
                e2[k][i] = !m_brk && (m_cnt >= m_act[k][i] + DEAD);
                ea[k][i] = (m_act[k][i] == m_tgt[i]);
            end
        end
        check_val("ramp.pwm1",    32'(pwm1_a), 32'(e1[0]));
        check_val("ramp.pwm2",    32'(pwm2_a), 32'(e2[0]));
        check_val("ramp.at_tgt",  32'(at_a),   32'(ea[0]));
        check_val("ramp.prd_end", 32'(prd_a),  32'(m_cnt == CMAX));
        check_val("ramp.excl",    32'(pwm1_a & pwm2_a), 32'd0);
        check_val("step.pwm1",    32'(pwm1_b), 32'(e1[1]));
        check_val("step.pwm2",    32'(pwm2_b), 32'(e2[1]));
        check_val("step.at_tgt",  32'(at_b),   32'(ea[1]));
        check_val("step.prd_end", 32'(prd_b),  32'(m_cnt == CMAX));
        check_val("step.excl",    32'(pwm1_b & pwm2_b), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        model_reset();
        brk_left = 0;
        run(3);
        rst_n = 1'b1;

        // unity scale, +500 on both channels; ch1 is inverted
        scale = UNITY_SCALE;
        spd   = {12'sd500, 12'sd500};
        for (int c = 0; c < 6 * 4096 && m_act[0][0] != 2304; c++) tick();
        run(200);
        brake = 1'b1;
        run(100);
        brake = 1'b0;
        run(8 * 4096 + 50);

        // saturation: 2047 * 4095 clips; -1 * 4095 truncates to -1
        spd   = {-12'sd1, 12'sd2047};
        scale = 13'sd4095;
        run(5000);

        // -1 at unity gives 0; -2048 at unity clips by one
        spd   = {-12'sd2048, -12'sd1};
        scale = UNITY_SCALE;
        run(4200);

        // brake and a new command landing in the prd_end cycle
        for (int c = 0; c < 4200 && m_cnt != CMAX; c++) tick();
        brake = 1'b1;
        spd   = {12'sd1000, -12'sd700};
        tick();
        brake = 1'b0;
        run(300);

        // random commands, scales and brake pulses
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                spd   = 24'($urandom);
                scale = 13'($urandom);
            end
            if (brk_left > 0) begin
                brake = 1'b1;
                brk_left--;
            end else begin
                brake = 1'b0;
                if ($urandom_range(0, 599) == 0) brk_left = int'($urandom_range(1, 60));
            end
            tick();
        end
        brake = 1'b0;

        // asynchronous reset in mid-period while driving
        spd   = {12'sd300, 12'sd900};
        scale = UNITY_SCALE;
        run(4200);
        for (int c = 0; c < 4200 && m_cnt != 1000; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        run(2);
        rst_n = 1'b1;
        run(4200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mtr_drv_ramp.md
# mtr_drv_ramp

Parametrised multi-channel motor driver, the successor to the current two-channel left/right driver. It scales each signed speed command by the battery scale factor and saturates the result. Each channel's duty ramps toward its target under a per-period slew limit, and the block drives complementary PWM pairs with programmable dead time. It sits between the PID/steering logic and the H-bridge pins; the existing duty-scale ROM stays at top level and feeds `scale`.

## Interface
Parameters:
- NUM_CH, 2, number of motor channels
- SPD_W, 12, width of each signed speed command
- PWM_W, 12, PWM counter/duty width; MID = 2^(PWM_W-1)
- DEAD, 16, dead-time counts at each edge of the PWM pair
- RAMP_STEP, 64, max duty change per PWM period; 0 = no limit
- INV_MASK, 'b10, bit i set = channel i direction inverted (duty = MID - scaled)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spd  in  NUM_CH*SPD_W  signed speed commands, channel i at [i*SPD_W +: SPD_W]
- scale  in  13  signed scale factor from the duty-scale ROM; 0x800 = unity
- brake  in  1  active high, forces all outputs low and re-centres the duty
- pwm1  out  NUM_CH  high-side PWM per channel
- pwm2  out  NUM_CH  low-side PWM per channel
- at_tgt  out  NUM_CH  duty_act equals duty_tgt
- prd_end  out  1  one-cycle pulse when cnt = 2^PWM_W-1

## Operation
- Stage 1 (registered) captures `spd` and `scale`.
- Stage 2 (registered) computes duty_tgt per channel:
  - prod = spd*scale, signed, SPD_W+13 bits.
  - q = prod/2048, truncating toward zero.
  - Saturate q to [-(MID-1), MID-1].
  - duty_tgt = MID + q, or MID - q when INV_MASK[i] is set. Range is always [1, 2^PWM_W-1].
- A shared free-running counter `cnt` (PWM_W bits) wraps from all-ones to 0.
- duty_act[i] updates only in the cycle where prd_end is high:
  - RAMP_STEP = 0: duty_act = duty_tgt.
  - Otherwise it moves toward duty_tgt by min(|diff|, RAMP_STEP) and never overshoots.
- Outputs, each registered:
  - pwm1[i] = (cnt >= DEAD) && (cnt < duty_act[i])
  - pwm2[i] = (cnt >= duty_act[i] + DEAD). The sum is evaluated at PWM_W+1 bits; if it exceeds all-ones, pwm2 stays low for that period.
  - pwm1 and pwm2 are never high together. Each active edge is separated from the other's by at least DEAD counts.
- Brake:
  - While brake is high, pwm1 = pwm2 = 0 from the next edge, regardless of period position.
  - duty_act is forced to MID every cycle.
  - At release, ramping restarts from MID at the next prd_end, so there is no step back to the old duty.
- at_tgt[i] is combinational from duty_act == duty_tgt.

## Timing
- Reset values: cnt=0, duty_tgt=MID, duty_act=MID, pwm1=0, pwm2=0, prd_end=0, at_tgt=1, stage-1 registers 0.
- Latency from spd/scale to duty_tgt is 2 cycles. The value becomes effective at the first prd_end after that, then ramps.
- PWM period = 2^PWM_W cycles. prd_end is high for exactly 1 cycle per period.
- If brake is asserted in the prd_end cycle, brake wins and duty_act becomes MID.
- A spd change in the prd_end cycle is not seen until the next period.
- Reset asserted mid-period clears everything asynchronously. The first period after reset starts at cnt=0.
- Saturation boundaries:
  - q = ±(MID-1) passes unchanged.
  - q = ±MID clips by 1.
  - Negative truncation: -1/2048 → 0.

## Structure
- Package mtr_drv_pkg holds:
  - the unity-scale constant 13'sh800 and the divide shift of 11
  - the sat_duty function (saturate and offset)
  - a typedef for the PWM_W-bit duty
- Sub-module mtr_ch_ramp, one instance per channel: ramp register, brake override, pwm1/pwm2 comparators, at_tgt.
- The counter, scale capture and prd_end live in the top level.

## Test plan
- Defaults, scale=0x800, spd = {ch0: +500, ch1: +500}, RAMP_STEP=0 → after 2 cycles plus the next prd_end: duty_act ch0=2548, ch1=1548. ch0 pwm1 is high for cnt 16..2547 and pwm2 for 2564..4095.
- spd ch0=2047, scale=4095 → q=4093 saturates to 2047, duty_tgt=4095. pwm2 is never high; pwm1 is high for cnt 16..4094.
- spd ch0=-1, scale=0x800 → q=0 (truncation toward zero), duty_tgt=2048.
- RAMP_STEP=64, target 2548 from MID → duty_act = 2112, 2176, …, 2496, 2548 on successive prd_end pulses. at_tgt rises at the 8th step.
- brake asserted mid-ramp at duty 2304 → pwm1 and pwm2 low on the next edge and duty_act=2048. After release, ramping restarts from 2048.
- rst_n pulsed low at cnt=1000 while driving → all outputs 0 immediately, duty_act=MID. cnt restarts at 0 after release.
- All scenarios run a continuous assertion that pwm1 & pwm2 are never high together.
